// File: rtl/seg_capture.sv
// Recovers hex bytes from a multiplexed 3-digit seven-segment display showing "h", high nibble, low nibble.
// Each digit must hold steady for STABLE_CYCLES clocks before it is decoded and fed to a framing FSM.
module seg_capture #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] segments,
  input  logic [2:0] segments_enable,
  output logic [7:0] hex_byte,
  output logic       byte_valid,
  output logic       frame_error,
  output logic       locked
);

  localparam int unsigned VEC_W = 11;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_EVT = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [2:0] EN_LEFT   = 3'b100;
  localparam logic [2:0] EN_CENTER = 3'b010;
  localparam logic [2:0] EN_RIGHT  = 3'b001;

  typedef enum logic [1:0] {
    WAIT_H = 2'd0,
    GET_HI = 2'd1,
    GET_LO = 2'd2
  } state_t;

  logic [VEC_W-1:0] sync1;
  logic [VEC_W-1:0] sync2;
  logic [VEC_W-1:0] cur_vec;
  logic [VEC_W-1:0] prev_vec;
  logic [CNT_W-1:0] stable_cnt;
  logic             same;
  logic             digit_evt;

  logic [7:0] seg_pat;
  logic [2:0] dig_en;
  logic       is_h;
  logic       hex_ok;
  logic [3:0] nibble;

  state_t     state;
  state_t     state_n;
  logic [3:0] hi_nib;
  logic [3:0] hi_nib_n;
  logic [7:0] hex_byte_n;
  logic       byte_valid_n;
  logic       frame_error_n;
  logic       locked_n;

  // Two-flop synchronizer on the raw active-low pins; resets to all-ones (blank, no digit enabled).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {segments, segments_enable};
      sync2 <= sync1;
    end
  end

  assign cur_vec = ~sync2;
  assign seg_pat = cur_vec[10:3];
  assign dig_en  = cur_vec[2:0];
  assign same    = (cur_vec == prev_vec);

  // Stability counter: restarts on any change, saturates once the digit is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vec   <= '0;
      stable_cnt <= '0;
    end else begin
      prev_vec <= cur_vec;
      if (!same) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

  // Fires on the cycle the counter steps onto STABLE_CYCLES; an all-off enable is not a digit.
  assign digit_evt = same && (stable_cnt == CNT_EVT) && (dig_en != 3'b000);

  // Pattern decode on segments a..g; DP is masked off.
  always_comb begin
    hex_ok = 1'b1;
    nibble = 4'h0;
    is_h   = 1'b0;
    case ({seg_pat[7:1], 1'b0})
      8'hFC: nibble = 4'h0;
      8'h60: nibble = 4'h1;
      8'hDA: nibble = 4'h2;
      8'hF2: nibble = 4'h3;
      8'h66: nibble = 4'h4;
      8'hB6: nibble = 4'h5;
      8'hBE: nibble = 4'h6;
      8'hE0: nibble = 4'h7;
      8'hFE: nibble = 4'h8;
      8'hF6: nibble = 4'h9;
      8'hEE: nibble = 4'hA;
      8'h3E: nibble = 4'hB;
      8'h9C: nibble = 4'hC;
      8'h7A: nibble = 4'hD;
      8'h9E: nibble = 4'hE;
      8'h8E: nibble = 4'hF;
      8'h2E: begin
        hex_ok = 1'b0;
        is_h   = 1'b1;
      end
      default: hex_ok = 1'b0;
    endcase
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_H;
      hi_nib      <= 4'h0;
      hex_byte    <= 8'h00;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= state_n;
      hi_nib      <= hi_nib_n;
      hex_byte    <= hex_byte_n;
      byte_valid  <= byte_valid_n;
      frame_error <= frame_error_n;
      locked      <= locked_n;
    end
  end

  always_comb begin
    state_n       = state;
    hi_nib_n      = hi_nib;
    hex_byte_n    = hex_byte;
    byte_valid_n  = 1'b0;
    frame_error_n = 1'b0;
    if (digit_evt) begin
      case (state)
        WAIT_H: begin
          if (dig_en == EN_LEFT && is_h) state_n = GET_HI;
        end
        GET_HI: begin
          if (dig_en == EN_CENTER && hex_ok) begin
            hi_nib_n = nibble;
            state_n  = GET_LO;
          end else if (dig_en == EN_LEFT && is_h) begin
            state_n = GET_HI;
          end else begin
            frame_error_n = 1'b1;
            state_n       = WAIT_H;
          end
        end
        GET_LO: begin
          if (dig_en == EN_RIGHT && hex_ok) begin
            hex_byte_n   = {hi_nib, nibble};
            byte_valid_n = 1'b1;
          end else begin
            frame_error_n = 1'b1;
          end
          state_n = WAIT_H;
        end
        default: state_n = WAIT_H;
      endcase
    end
    locked_n = locked;
    if (byte_valid_n) begin
      locked_n = 1'b1;
    end else if (frame_error_n) begin
      locked_n = 1'b0;
    end
  end

endmodule
